// File: rtl/pzcorebus_upsizer_response_sequencer_pkg.sv
// pzcorebus_upsizer_response_sequencer_pkg: shared types and helpers for the upsizer response sequencer.
package pzcorebus_upsizer_response_sequencer_pkg;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_BURST
    } seq_state_e;

    // Index width for a power-of-2 unit count; never below 1 bit so ports stay legal.
    function automatic int index_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/pzcorebus_upsizer_response_sequencer_fifo.sv
// pzcorebus_upsizer_response_sequencer_fifo: command queue exposing the entry behind the head and the fill count.
module pzcorebus_upsizer_response_sequencer_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_next_data,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    // The head itself is held in the sequencer's counters; only its successor is needed here.
    assign o_next_data = mem[rd_ptr + PW'(1)];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + PW'(1);
            if (i_pop) rd_ptr <= rd_ptr + PW'(1);
            if (i_push != i_pop) o_count <= i_push ? o_count + CW'(1) : o_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pzcorebus_upsizer_response_sequencer.sv
// pzcorebus_upsizer_response_sequencer: per-command unit/lane index, narrow last and wide-beat pop
// generation for the upsizer response path.
module pzcorebus_upsizer_response_sequencer
    import pzcorebus_upsizer_response_sequencer_pkg::*;
#(
    parameter int MAX_DATA_SIZE    = 16,
    parameter int SLAVE_DATA_SIZE  = 2,
    parameter int MASTER_DATA_SIZE = 8,
    parameter int LENGTH_WIDTH     = 8,
    parameter int DEPTH            = 4
)(
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_cmd_valid,
    output logic                                      o_cmd_ready,
    input  logic [index_width(MAX_DATA_SIZE)-1:0]     i_cmd_offset,
    input  logic [LENGTH_WIDTH-1:0]                   i_cmd_length,
    input  logic                                      i_resp_ack,
    output logic                                      o_resp_enable,
    output logic [index_width(MAX_DATA_SIZE)-1:0]     o_unit_index,
    output logic [index_width(MASTER_DATA_SIZE)-1:0]  o_lane_index,
    output logic                                      o_resp_last,
    output logic                                      o_master_pop
);
    localparam int UW = index_width(MAX_DATA_SIZE);
    localparam int LW = index_width(MASTER_DATA_SIZE);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [UW-1:0]           offset;
        logic [LENGTH_WIDTH-1:0] length;
    } entry_t;

    seq_state_e              state_q;
    seq_state_e              state_d;
    logic [UW-1:0]           index_q;
    logic [UW-1:0]           index_d;
    logic [LENGTH_WIDTH-1:0] remain_q;
    logic [LENGTH_WIDTH-1:0] remain_d;
    logic [CW-1:0]           count;
    entry_t                  cmd_entry;
    entry_t                  next_entry;
    entry_t                  load_entry;
    logic                    push;
    logic                    pop;

    assign cmd_entry     = '{offset: i_cmd_offset & ~UW'(SLAVE_DATA_SIZE - 1), length: i_cmd_length};
    assign o_cmd_ready   = count != CW'(DEPTH);
    assign push          = i_cmd_valid && o_cmd_ready;
    assign o_resp_enable = state_q == SEQ_BURST;
    assign o_resp_last   = o_resp_enable && remain_q == '0;
    assign pop           = o_resp_enable && i_resp_ack && o_resp_last;
    assign o_unit_index  = index_q;
    assign o_lane_index  = LW'(index_q);
    assign o_master_pop  = o_resp_enable && (o_resp_last ||
                           ((index_q + UW'(SLAVE_DATA_SIZE)) & UW'(MASTER_DATA_SIZE - 1)) == '0);
    // With only the finishing head queued, a same-cycle push becomes the next head directly.
    assign load_entry    = (count > CW'(1)) ? next_entry : cmd_entry;

    pzcorebus_upsizer_response_sequencer_fifo #(
        .DATA_WIDTH ($bits(entry_t)),
        .DEPTH      (DEPTH)
    ) u_cmd_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_data      (cmd_entry),
        .i_pop       (pop),
        .o_next_data (next_entry),
        .o_count     (count)
    );

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        remain_d = remain_q;
        if (state_q == SEQ_IDLE) begin
            if (push) begin
                state_d  = SEQ_BURST;
                index_d  = cmd_entry.offset;
                remain_d = cmd_entry.length;
            end
        end else if (i_resp_ack) begin
            if (!o_resp_last) begin
                index_d  = index_q + UW'(SLAVE_DATA_SIZE);
                remain_d = remain_q - LENGTH_WIDTH'(1);
            end else if (count > CW'(1) || push) begin
                index_d  = load_entry.offset;
                remain_d = load_entry.length;
            end else begin
                state_d  = SEQ_IDLE;
                index_d  = '0;
                remain_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= SEQ_IDLE;
            index_q  <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            remain_q <= remain_d;
        end
    end

    ack_needs_enable: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_resp_ack |-> o_resp_enable);

endmodule

// File: tb/tb_pzcorebus_upsizer_response_sequencer.sv
// tb_pzcorebus_upsizer_response_sequencer: directed scenarios with hand-computed expectations
// for the default configuration (MAX=16, SLAVE=2, MASTER=8, LENGTH_WIDTH=8, DEPTH=4).
module tb_pzcorebus_upsizer_response_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       resp_ack = 1'b0;
    logic [3:0] cmd_offset = 4'd0;
    logic [7:0] cmd_length = 8'd0;
    logic       cmd_ready;
    logic       resp_enable;
    logic       resp_last;
    logic       master_pop;
    logic [3:0] unit_index;
    logic [2:0] lane_index;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pzcorebus_upsizer_response_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_offset  (cmd_offset),
        .i_cmd_length  (cmd_length),
        .i_resp_ack    (resp_ack),
        .o_resp_enable (resp_enable),
        .o_unit_index  (unit_index),
        .o_lane_index  (lane_index),
        .o_resp_last   (resp_last),
        .o_master_pop  (master_pop)
    );

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({resp_enable, resp_last, master_pop, unit_index, lane_index, cmd_ready} !== 11'b000_0000_000_1) begin
            errors++;
            $display("FAIL reset: en=%b last=%b pop=%b unit=%0d lane=%0d ready=%b, expected all 0 and ready=1",
                     resp_enable, resp_last, master_pop, unit_index, lane_index, cmd_ready);
        end
        rst_n = 1'b1;
    endtask

    // Commands: (4,3) straight run, (14,1) wrap past 15, (5,0) unaligned offset.
    task automatic test_bursts();
        logic [3:0] offs [3] = '{4'd4, 4'd14, 4'd5};
        logic [7:0] lens [3] = '{8'd3, 8'd1, 8'd0};
        logic [3:0] eu [7]   = '{4'd4, 4'd6, 4'd8, 4'd10, 4'd14, 4'd0, 4'd4};
        logic       el [7]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       ep [7]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int k = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_offset = offs[c]; cmd_length = lens[c];
            for (int j = 0; j <= int'(lens[c]); j++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                checks++;
                if ({resp_enable, unit_index, lane_index, resp_last, master_pop} !== {1'b1, eu[k], eu[k][2:0], el[k], ep[k]}) begin
                    errors++;
                    $display("FAIL burst beat %0d: en=%b unit=%0d lane=%0d last=%b pop=%b, expected en=1 unit=%0d lane=%0d last=%b pop=%b",
                             k, resp_enable, unit_index, lane_index, resp_last, master_pop, eu[k], eu[k][2:0], el[k], ep[k]);
                end
                resp_ack = 1'b1;
                k++;
            end
            @(negedge clk);
            resp_ack = 1'b0;
            checks++;
            if (resp_enable !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL burst %0d idle: en=%b ready=%b, expected en=0 ready=1", c, resp_enable, cmd_ready);
            end
        end
    endtask

    task automatic test_full_queue();
        logic [3:0] offs [4]  = '{4'd0, 4'd2, 4'd8, 4'd6};
        logic [7:0] lens [4]  = '{8'd1, 8'd0, 8'd0, 8'd0};
        logic [3:0] drain [3] = '{4'd8, 4'd6, 4'd12};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_offset = offs[i]; cmd_length = lens[i];
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0 || resp_enable !== 1'b1 || unit_index !== 4'd0) begin
                errors++;
                $display("FAIL full hold %0d: ready=%b en=%b unit=%0d, expected ready=0 en=1 unit=0", i, cmd_ready, resp_enable, unit_index);
            end
            cmd_offset = 4'd12; cmd_length = 8'd0;
        end
        @(negedge clk);
        checks++;
        if ({cmd_ready, unit_index, resp_last} !== {1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL full beat0: ready=%b unit=%0d last=%b, expected ready=0 unit=0 last=0", cmd_ready, unit_index, resp_last);
        end
        resp_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, unit_index, resp_last} !== {1'b0, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL full beat1: ready=%b unit=%0d last=%b, expected ready=0 unit=2 last=1", cmd_ready, unit_index, resp_last);
        end
        @(negedge clk);
        checks++;
        if ({cmd_ready, resp_enable, unit_index, resp_last} !== {1'b1, 1'b1, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL full reopen: ready=%b en=%b unit=%0d last=%b, expected ready=1 en=1 unit=2 last=1",
                     cmd_ready, resp_enable, unit_index, resp_last);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++;
            if ({resp_enable, unit_index, resp_last, master_pop} !== {1'b1, drain[i], 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL full drain %0d: en=%b unit=%0d last=%b pop=%b, expected en=1 unit=%0d last=1 pop=1",
                         i, resp_enable, unit_index, resp_last, master_pop, drain[i]);
            end
        end
        @(negedge clk);
        resp_ack = 1'b0;
        checks++;
        if (resp_enable !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL full idle: en=%b ready=%b, expected en=0 ready=1", resp_enable, cmd_ready);
        end
    endtask

    task automatic test_push_on_last();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_offset = 4'd0; cmd_length = 8'd0;
        @(negedge clk);
        checks++;
        if ({resp_enable, unit_index, resp_last} !== {1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL swap first: en=%b unit=%0d last=%b, expected en=1 unit=0 last=1", resp_enable, unit_index, resp_last);
        end
        cmd_offset = 4'd10; cmd_length = 8'd1; resp_ack = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({resp_enable, unit_index, lane_index, resp_last, master_pop, cmd_ready} !== {1'b1, 4'd10, 3'd2, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL swap next: en=%b unit=%0d lane=%0d last=%b pop=%b ready=%b, expected en=1 unit=10 lane=2 last=0 pop=0 ready=1",
                     resp_enable, unit_index, lane_index, resp_last, master_pop, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if ({resp_enable, unit_index, lane_index, resp_last, master_pop} !== {1'b1, 4'd12, 3'd4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL swap last: en=%b unit=%0d lane=%0d last=%b pop=%b, expected en=1 unit=12 lane=4 last=1 pop=1",
                     resp_enable, unit_index, lane_index, resp_last, master_pop);
        end
        @(negedge clk);
        resp_ack = 1'b0;
        checks++;
        if (resp_enable !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL swap idle: en=%b ready=%b, expected en=0 ready=1", resp_enable, cmd_ready);
        end
    endtask

    // length=255 must run 256 beats; last index is (0 + 255*2) mod 16 = 14.
    task automatic test_max_length();
        int         beats = 0;
        bit         seen = 1'b0;
        logic [3:0] last_unit = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_offset = 4'd0; cmd_length = 8'd255;
        @(negedge clk);
        cmd_valid = 1'b0; resp_ack = 1'b1;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (i > 0) @(negedge clk);
            if (resp_enable) beats++;
            seen = resp_last;
            last_unit = unit_index;
        end
        checks++;
        if (!seen || beats != 256 || last_unit !== 4'd14) begin
            errors++;
            $display("FAIL max length: last_seen=%b beats=%0d last_unit=%0d, expected last_seen=1 beats=256 last_unit=14", seen, beats, last_unit);
        end
        @(negedge clk);
        resp_ack = 1'b0;
        checks++;
        if (resp_enable !== 1'b0) begin
            errors++;
            $display("FAIL max length idle: en=%b, expected 0", resp_enable);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_offset = 4'd4; cmd_length = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0; resp_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({resp_enable, unit_index, resp_last} !== {1'b1, 4'd6, 1'b0}) begin
            errors++;
            $display("FAIL midreset beat2: en=%b unit=%0d last=%b, expected en=1 unit=6 last=0", resp_enable, unit_index, resp_last);
        end
        rst_n = 1'b0; resp_ack = 1'b0;
        #1;
        checks++;
        if ({resp_enable, resp_last, master_pop, unit_index, lane_index, cmd_ready} !== 11'b000_0000_000_1) begin
            errors++;
            $display("FAIL midreset outputs: en=%b last=%b pop=%b unit=%0d lane=%0d ready=%b, expected all 0 and ready=1",
                     resp_enable, resp_last, master_pop, unit_index, lane_index, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_offset = 4'd8; cmd_length = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({resp_enable, unit_index, lane_index, resp_last, master_pop} !== {1'b1, 4'd8, 3'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL midreset restart: en=%b unit=%0d lane=%0d last=%b pop=%b, expected en=1 unit=8 lane=0 last=1 pop=1",
                     resp_enable, unit_index, lane_index, resp_last, master_pop);
        end
        resp_ack = 1'b1;
        @(negedge clk);
        resp_ack = 1'b0;
        checks++;
        if (resp_enable !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset idle: en=%b ready=%b, expected en=0 ready=1", resp_enable, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_bursts();
        test_full_queue();
        test_push_on_last();
        test_max_length();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
